// File: rtl/nodemem_arbiter.sv
// Three-requester round-robin arbiter that serialises 16-bit word accesses
// onto a byte-wide node memory with one-cycle read latency.
module nodemem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int MEM_WIDTH  = 8,
    parameter int WORD_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    en,
    input  logic [2:0]              req,
    input  logic [2:0]              req_wr,
    input  logic [3*ADDR_WIDTH-1:0] req_addr,
    input  logic [3*WORD_WIDTH-1:0] req_wdata,
    output logic [2:0]              ack,
    output logic [WORD_WIDTH-1:0]   rdata,
    output logic                    busy,
    output logic [1:0]              gnt_id,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wr_en,
    output logic [MEM_WIDTH-1:0]    mem_wdata,
    input  logic [MEM_WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;

    state_t                          state;
    logic [1:0]                      rr_ptr;
    logic [1:0]                      pick;
    logic                            found;
    logic [2:0]                      idx;
    logic                            sel_wr;
    logic [ADDR_WIDTH-1:0]           sel_addr;
    logic [WORD_WIDTH-1:0]           sel_wdata;
    logic                            lat_wr;
    logic [ADDR_WIDTH-1:0]           lat_addr;
    logic [WORD_WIDTH-MEM_WIDTH-1:0] lat_wdata_hi;
    logic [MEM_WIDTH-1:0]            lo_byte;
    logic [WORD_WIDTH-1:0]           rdata_hold;
    logic                            wr_strobe;

    // Round-robin search starting at rr_ptr, wrapping modulo 3.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = {1'b0, rr_ptr} + 3'(k);
            if (idx >= 3'd3)
                idx = idx - 3'd3;
            if (!found && req[idx]) begin
                pick  = idx[1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_wr    = req_wr[0];
        sel_addr  = req_addr[0 +: ADDR_WIDTH];
        sel_wdata = req_wdata[0 +: WORD_WIDTH];
        for (int unsigned i = 0; i < 3; i++) begin
            if (pick == 2'(i)) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            ack          <= '0;
            gnt_id       <= 2'd3;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wr_strobe    <= 1'b0;
            lat_wr       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata_hi <= '0;
            lo_byte      <= '0;
            rdata_hold   <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (en && found) begin
                        state        <= LO;
                        gnt_id       <= pick;
                        lat_wr       <= sel_wr;
                        lat_addr     <= sel_addr;
                        lat_wdata_hi <= sel_wdata[WORD_WIDTH-1:MEM_WIDTH];
                        mem_addr     <= sel_addr;
                        mem_wdata    <= sel_wdata[MEM_WIDTH-1:0];
                        wr_strobe    <= sel_wr;
                    end
                end
                LO: begin
                    state     <= HI;
                    mem_addr  <= lat_addr + 1'b1;
                    mem_wdata <= lat_wdata_hi;
                    wr_strobe <= lat_wr;
                end
                HI: begin
                    state     <= ACK;
                    wr_strobe <= 1'b0;
                    ack       <= 3'b001 << gnt_id;
                    if (!lat_wr)
                        lo_byte <= mem_rdata;
                end
                ACK: begin
                    state  <= IDLE;
                    gnt_id <= 2'd3;
                    rr_ptr <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
                    if (!lat_wr)
                        rdata_hold <= {mem_rdata, lo_byte};
                end
                default: state <= IDLE;
            endcase
        end
    end

    // High byte only arrives during ACK, so the read word is assembled
    // combinationally there and held from the register afterwards.
    assign rdata = (state == ACK && !lat_wr) ? {mem_rdata, lo_byte} : rdata_hold;

    // Gating with rst keeps an aborted transaction from writing on the reset edge.
    assign mem_wr_en = wr_strobe & ~rst;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nodemem_arbiter.sv
// Directed bench for nodemem_arbiter with a behavioural byte memory model.
module tb_nodemem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  req;
    logic [2:0]  req_wr;
    logic [32:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic [1:0]  gnt_id;
    logic [10:0] mem_addr;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:2047];

    int total = 0;
    int bad   = 0;

    nodemem_arbiter #(.ADDR_WIDTH(11), .MEM_WIDTH(8), .WORD_WIDTH(16)) dut (
        .clock(clk), .rst(rst), .en(en), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .busy(busy), .gnt_id(gnt_id), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic wr, input logic [10:0] a, input logic [15:0] d);
        req_wr[id]            = wr;
        req_addr[id*11 +: 11] = a;
        req_wdata[id*16 +: 16] = d;
    endtask

    // Full transaction from IDLE; ack must appear on the third edge.
    task automatic run_txn(input int id, input logic wr, input logic [10:0] a, input logic [15:0] d);
        int n;
        set_req(id, wr, a, d);
        req[id] = 1'b1;
        n = 0;
        do begin
            step;
            n++;
        end while (ack[id] !== 1'b1 && n < 8);
        chk("txn_latency", n, 3);
        req[id] = 1'b0;
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int order3 [3];
        int order2 [2];
        order3 = '{0, 1, 2};
        order2 = '{0, 2};

        rst = 1'b1; en = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        step; step;
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 3);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_wren", mem_wr_en, 0);
        chk("rst_wdata", mem_wdata, 0);
        rst = 1'b0;

        // single write from requester 1
        set_req(1, 1'b1, 11'h100, 16'hBEEF);
        req = 3'b010;
        step;
        chk("wr_lo_busy", busy, 1);
        chk("wr_lo_gnt", gnt_id, 1);
        chk("wr_lo_addr", mem_addr, 11'h100);
        chk("wr_lo_wren", mem_wr_en, 1);
        chk("wr_lo_wdata", mem_wdata, 8'hEF);
        chk("wr_lo_ack", ack, 0);
        set_req(1, 1'b0, 11'h555, 16'h0000);
        step;
        chk("wr_hi_addr", mem_addr, 11'h101);
        chk("wr_hi_wdata", mem_wdata, 8'hBE);
        chk("wr_hi_wren", mem_wr_en, 1);
        chk("wr_hi_ack", ack, 0);
        step;
        chk("wr_ack", ack, 3'b010);
        chk("wr_ack_wren", mem_wr_en, 0);
        chk("wr_ack_rdata", rdata, 0);
        req = 3'b000;
        step;
        chk("wr_idle_ack", ack, 0);
        chk("wr_idle_busy", busy, 0);
        chk("wr_idle_gnt", gnt_id, 3);
        chk("wr_mem_lo", mem[11'h100], 8'hEF);
        chk("wr_mem_hi", mem[11'h101], 8'hBE);

        // read-back by requester 0
        set_req(0, 1'b0, 11'h100, 16'h0000);
        req = 3'b001;
        step;
        chk("rd_lo_gnt", gnt_id, 0);
        chk("rd_lo_addr", mem_addr, 11'h100);
        chk("rd_lo_wren", mem_wr_en, 0);
        step;
        chk("rd_hi_addr", mem_addr, 11'h101);
        chk("rd_hi_wren", mem_wr_en, 0);
        step;
        chk("rd_ack", ack, 3'b001);
        chk("rd_ack_rdata", rdata, 16'hBEEF);
        chk("rd_ack_wren", mem_wr_en, 0);
        req = 3'b000;
        step;
        chk("rd_hold_rdata", rdata, 16'hBEEF);
        chk("rd_idle_ack", ack, 0);

        // address wrap from 0x7FF to 0x000
        set_req(2, 1'b1, 11'h7FF, 16'h1234);
        req = 3'b100;
        step;
        chk("wrap_lo_addr", mem_addr, 11'h7FF);
        chk("wrap_lo_wdata", mem_wdata, 8'h34);
        step;
        chk("wrap_hi_addr", mem_addr, 11'h000);
        chk("wrap_hi_wdata", mem_wdata, 8'h12);
        step;
        chk("wrap_ack", ack, 3'b100);
        chk("wrap_ack_rdata", rdata, 16'hBEEF);
        req = 3'b000;
        step;
        chk("wrap_mem_lo", mem[11'h7FF], 8'h34);
        chk("wrap_mem_hi", mem[11'h000], 8'h12);
        chk("wrap_rdata_kept", rdata, 16'hBEEF);

        // contention: all three, then 0 and 2
        set_req(0, 1'b0, 11'h100, 16'h0000);
        set_req(1, 1'b0, 11'h100, 16'h0000);
        set_req(2, 1'b0, 11'h100, 16'h0000);
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                step;
                n++;
            end while (ack === 3'b000 && n < 8);
            chk("cont3_lat", n, 3);
            chk("cont3_ack", ack, 3'b001 << order3[i]);
            chk("cont3_rdata", rdata, 16'hBEEF);
            req = req & ~ack;
            step;
        end
        req = 3'b101;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            do begin
                step;
                n++;
            end while (ack === 3'b000 && n < 8);
            chk("cont2_lat", n, 3);
            chk("cont2_ack", ack, 3'b001 << order2[i]);
            req = req & ~ack;
            step;
        end
        req = 3'b011;
        step;
        chk("cont_wrap_gnt", gnt_id, 0);
        step; step;
        chk("cont_wrap_ack", ack, 3'b001);
        req = 3'b000;
        step;

        // reset during HI of a write
        run_txn(2, 1'b1, 11'h200, 16'h1111);
        set_req(2, 1'b1, 11'h200, 16'hA55A);
        req = 3'b100;
        step;
        step;
        chk("abort_hi_addr", mem_addr, 11'h201);
        rst = 1'b1;
        step;
        rst = 1'b0;
        req = 3'b000;
        chk("abort_ack", ack, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gnt", gnt_id, 3);
        chk("abort_wren", mem_wr_en, 0);
        chk("abort_mem_lo", mem[11'h200], 8'h5A);
        chk("abort_mem_hi", mem[11'h201], 8'h11);
        step;
        chk("abort_noack", ack, 0);

        // enable gating
        en = 1'b0;
        set_req(2, 1'b0, 11'h100, 16'h0000);
        req = 3'b100;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("en_off_busy", busy, 0);
            chk("en_off_gnt", gnt_id, 3);
        end
        en = 1'b1;
        step;
        chk("en_on_gnt", gnt_id, 2);
        chk("en_on_busy", busy, 1);
        en = 1'b0;
        step; step;
        chk("en_drop_ack", ack, 3'b100);
        chk("en_drop_rdata", rdata, 16'hBEEF);
        req = 3'b000;
        en = 1'b1;
        step;
        chk("en_end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nodemem_arbiter.md
NODEMEM_ARBITER -- requirements
Module: nodemem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 11, node memory address width (2048 bytes).
REQ-002 Parameter: MEM_WIDTH, 8, memory byte width.
REQ-003 Parameter: WORD_WIDTH, 16, requester word width.
REQ-004 Port: clock  in  1  sole clock; all logic on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: en  in  1  arbitration enable; low blocks new grants only.
REQ-007 Port: req  in  3  per-requester request: bit0 packet handler, bit1 winner policy, bit2 Q-update.
REQ-008 Port: req_wr  in  3  per-requester write flag, 1 = write, 0 = read.
REQ-009 Port: req_addr  in  33  per-requester byte address; requester i uses bits [11i+10:11i].
REQ-010 Port: req_wdata  in  48  per-requester write word; requester i uses bits [16i+15:16i].
REQ-011 Port: ack  out  3  one-cycle completion pulse to the served requester.
REQ-012 Port: rdata  out  16  read word, valid only in the ack cycle of a read.
REQ-013 Port: busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 Port: gnt_id  out  2  index of the latched winner; 3 when idle.
REQ-015 Port: mem_addr  out  11  node memory address.
REQ-016 Port: mem_wr_en  out  1  node memory byte write strobe.
REQ-017 Port: mem_wdata  out  8  node memory write byte.
REQ-018 Port: mem_rdata  in  8  node memory read byte; one-cycle latency (address at t gives data at t+1).

Function
REQ-019 FSM states SHALL be IDLE, LO, HI, ACK.
REQ-020 Transitions SHALL be: IDLE->LO when en=1 and req!=0; LO->HI; HI->ACK; ACK->IDLE. All are unconditional except the exit from IDLE.
REQ-021 In IDLE the arbiter SHALL pick the winner round-robin, searching from rr_ptr upward modulo 3, and latch the winner's index, req_wr, req_addr and req_wdata.
REQ-022 In LO the block SHALL drive mem_addr=latched addr, mem_wdata=wdata[7:0] and mem_wr_en=latched wr.
REQ-023 In HI the block SHALL drive mem_addr=latched addr+1, wrapping 2047->0, with mem_wdata=wdata[15:8] and mem_wr_en=latched wr; on a read it captures mem_rdata as the low byte.
REQ-024 In ACK the block SHALL capture mem_rdata as the high byte, drive rdata={high,low}, pulse ack[winner], and set rr_ptr=(winner+1) mod 3.
REQ-025 mem_wr_en SHALL be 0 in IDLE and ACK, and SHALL never be asserted for a read.
REQ-026 Latency SHALL be fixed: request sampled in IDLE at cycle t gives ack at t+3; at most one transaction per 4 cycles.
REQ-027 Requests latched in IDLE SHALL complete even if req or en drops mid-transaction, and changes to req_addr, req_wdata or req_wr after the latch SHALL be ignored.
REQ-028 Requesters SHALL deassert req in the same cycle ack is high; req still high in the following IDLE cycle counts as a new request.
REQ-029 Simultaneous requests SHALL be served strictly round-robin with no starvation: a continuously asserted request is granted within 3 transactions.
REQ-030 rdata SHALL hold its last value outside ack cycles, and write transactions SHALL leave rdata unchanged.

Reset
REQ-031 While rst=1 the FSM SHALL go to IDLE, with rr_ptr=0, ack=0, rdata=0, busy=0, gnt_id=3, mem_addr=0, mem_wr_en=0, mem_wdata=0.
REQ-032 A reset asserted mid-transaction SHALL abort it with no ack and no further memory write; arbitration restarts from rr_ptr=0.

Verification
REQ-033 Single write: req=010, addr 0x100, wdata 0xBEEF -> byte 0x100=0xEF and byte 0x101=0xBE; ack=010 exactly 3 cycles after the request is sampled.
REQ-034 Read-back: req=001 read at addr 0x100 -> rdata=0xBEEF in the ack cycle; mem_wr_en stays 0 throughout.
REQ-035 Wrap: write 0x1234 at addr 0x7FF -> byte 0x7FF=0x34 and byte 0x000=0x12.
REQ-036 Contention: req=111 held, each requester dropping req on its ack -> grant order 0,1,2; then req=101 re-raised -> order 0,2 with rr_ptr wrapping.
REQ-037 Control: rst pulsed in HI during a write -> no ack, high byte not written, busy=0 next cycle; with en=0 and req=100 -> no grant until en=1.
